// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit, the mul/div units and the muldiv sequencer.
// The master side is the control unit plus the arithmetic units; the slave side is the sequencer.
interface muldiv_sequencer_if;
  logic req;
  logic op;
  logic busy;
  logic done;
  logic div_zero_exc;
  logic timeout_err;
  logic start_mult;
  logic stop_mult;
  logic start_div;
  logic stop_div;
  logic div_zero;
  logic hilo_sel;
  logic hi_write;
  logic lo_write;

  modport master (
    output req, op, stop_mult, stop_div, div_zero,
    input  busy, done, div_zero_exc, timeout_err, start_mult, start_div,
           hilo_sel, hi_write, lo_write
  );

  modport slave (
    input  req, op, stop_mult, stop_div, div_zero,
    output busy, done, div_zero_exc, timeout_err, start_mult, start_div,
           hilo_sel, hi_write, lo_write
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Launches the multiply or divide unit, waits for its stop handshake and writes HI/LO,
// reporting done / divide-by-zero / timeout as one-cycle pulses.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, WRITE, EXC, ERR
  } state_t;

  state_t           state;
  logic             opQ;
  logic [CNT_W-1:0] cnt;

  logic busyQ, doneQ, excQ, errQ, startMultQ, startDivQ, hiloSelQ, writeQ;

  logic unitStop;
  assign unitStop = opQ ? bus.stop_div : bus.stop_mult;

  // Every output register is loaded on the edge that enters the state it belongs to,
  // so outputs are pure functions of the current state and never of current inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      opQ        <= 1'b0;
      cnt        <= '0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      excQ       <= 1'b0;
      errQ       <= 1'b0;
      startMultQ <= 1'b0;
      startDivQ  <= 1'b0;
      hiloSelQ   <= 1'b0;
      writeQ     <= 1'b0;
    end else begin
      doneQ      <= 1'b0;
      excQ       <= 1'b0;
      errQ       <= 1'b0;
      startMultQ <= 1'b0;
      startDivQ  <= 1'b0;
      writeQ     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state      <= LAUNCH;
            opQ        <= bus.op;
            busyQ      <= 1'b1;
            hiloSelQ   <= bus.op;
            startMultQ <= ~bus.op;
            startDivQ  <= bus.op;
          end
        end
        LAUNCH: begin
          // Stop and div_zero are not looked at here; the unit was only just started.
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (opQ && bus.div_zero) begin
            state <= EXC;
            excQ  <= 1'b1;
          end else if (unitStop) begin
            state  <= WRITE;
            doneQ  <= 1'b1;
            writeQ <= 1'b1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= ERR;
            errQ  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE, EXC, ERR: begin
          state    <= IDLE;
          busyQ    <= 1'b0;
          hiloSelQ <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busyQ    <= 1'b0;
          hiloSelQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busyQ;
  assign bus.done         = doneQ;
  assign bus.div_zero_exc = excQ;
  assign bus.timeout_err  = errQ;
  assign bus.start_mult   = startMultQ;
  assign bus.start_div    = startDivQ;
  assign bus.hilo_sel     = hiloSelQ;
  assign bus.hi_write     = writeQ;
  assign bus.lo_write     = writeQ;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multicycle CPU's multiply and divide units. It accepts a one-cycle request from the main control unit and issues the start pulse to the selected unit. It then waits for that unit's stop handshake, sets the select of the HI/LO source mux, and pulses the HI and LO register write enables. It reports done, divide-by-zero or timeout back to the control unit as one-cycle pulses, so the control FSM only needs to wait on `busy`.

## Interface

Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `TIMEOUT`, default 40: maximum number of WAIT cycles before the operation is abandoned. Legal range is 2 to 255.
- `CNT_W`, default 8: width of the WAIT-cycle counter. It must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE.
- `req`  in  1  operation request from the control unit; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide; sampled together with `req`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; HI/LO are written on the same edge.
- `div_zero_exc`  out  1  one-cycle pulse; divide by zero, HI/LO not written.
- `timeout_err`  out  1  one-cycle pulse; unit never stopped, HI/LO not written.
- `start_mult`  out  1  one-cycle start pulse to the multiplier.
- `stop_mult`  in  1  multiplier finished; level or pulse.
- `start_div`  out  1  one-cycle start pulse to the divider.
- `stop_div`  in  1  divider finished.
- `div_zero`  in  1  divider flags divisor == 0.
- `hilo_sel`  out  1  HI/LO source mux select: 0 = multiplier, 1 = divider.
- `hi_write`  out  1  HI register write enable.
- `lo_write`  out  1  LO register write enable.

## Operation

Internal state:
- `op_q`: latched operation.
- `cnt`: WAIT-cycle counter, CNT_W bits.
- FSM states: IDLE, LAUNCH, WAIT, WRITE, EXC, ERR.

State behaviour:
- IDLE: all outputs 0. If `req`=1, latch `op` into `op_q` and go to LAUNCH; otherwise stay.
- LAUNCH: assert `start_mult` if `op_q`=0, or `start_div` if `op_q`=1. Clear `cnt`. Go to WAIT.
- WAIT: evaluated in priority order each cycle:
  1. `op_q`=1 and `div_zero`=1: go to EXC.
  2. The selected unit's stop is 1: go to WRITE.
  3. `cnt` == TIMEOUT-1: go to ERR.
  4. Otherwise `cnt` increments and the FSM stays in WAIT.
- WRITE: assert `hi_write`, `lo_write` and `done`. Go to IDLE.
- EXC: assert `div_zero_exc`. Go to IDLE.
- ERR: assert `timeout_err`. Go to IDLE.

Output rules:
- `hilo_sel` = `op_q` in every non-IDLE state and 0 in IDLE. It is stable for the whole operation, including the WRITE cycle.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Ignored inputs:
- `req` outside IDLE. There is no queue and no error is raised.
- The non-selected unit's stop, e.g. `stop_div` during a multiply.
- `div_zero` during a multiply.
- Any stop or `div_zero` seen in LAUNCH; the unit has only just been started.

Reset:
- State goes to IDLE; `op_q`, `cnt` and all outputs go to 0.
- Reset mid-operation abandons it silently: no `done`, error pulse or write is issued, and the unit is not restarted.

## Timing

Reset values: every output is 0 in the cycle after `reset` is sampled high.

Reference timeline, with `req` sampled in IDLE at cycle 0:
- cycle 1: LAUNCH; start pulse; `busy`=1.
- cycle 2: first WAIT cycle, `cnt`=0.
- A stop or `div_zero` sampled at cycle k (k ≥ 2) produces WRITE, EXC or ERR at cycle k+1. IDLE follows at k+2.

Latency:
- Minimum request-to-`done` latency is 3 cycles (stop at cycle 2).
- A new `req` is accepted no earlier than cycle k+2.

Timeout:
- The last WAIT cycle is cycle TIMEOUT+1, where `cnt`=TIMEOUT-1.
- A stop sampled in that cycle still wins and goes to WRITE; otherwise ERR follows at cycle TIMEOUT+2.

Pulse widths: `done`, `div_zero_exc`, `timeout_err` and the start pulses are exactly one cycle wide and mutually exclusive.

## Test plan

- Multiply: reset, then `req`=1, `op`=0 at cycle 0, `stop_mult`=1 at cycle 5. Expect `start_mult` only at cycle 1; `hi_write`, `lo_write` and `done` at cycle 6 with `hilo_sel`=0; `busy` high for cycles 1–6.
- Fastest divide: `req`, `op`=1 at cycle 0, `stop_div` at cycle 2. Expect `start_div` at cycle 1; `done`, `hi_write` and `lo_write` at cycle 3 with `hilo_sel`=1; a `req` at cycle 4 accepted with LAUNCH at cycle 5.
- Divide by zero: `req`, `op`=1, then `div_zero`=1 and `stop_div`=1 both at cycle 4. Expect `div_zero_exc` at cycle 5; `hi_write`, `lo_write` and `done` stay 0 throughout.
- Timeout, TIMEOUT=40, multiply:
  - With no stop: `timeout_err` at cycle 42, `busy`=0 at cycle 43.
  - Rerun with `stop_mult` at cycle 41: `done` at cycle 42 and no `timeout_err`.
- Ignored inputs during a multiply: `stop_div` and `div_zero` at cycle 3, `req`=1 with `op`=1 at cycle 4, `stop_mult` at cycle 6. Expect a single `done` at cycle 7 with `hilo_sel`=0 and no `start_div` anywhere.
- Reset mid-divide: `reset` at cycle 3, then `stop_div` at cycle 5. Expect all outputs 0 from cycle 4 and no `done`, `hi_write` or error pulse at any time.
